serial_command_initiator: RTL and testbench
===========================================

# serial_command_initiator

Host-side master for the serial memory-command protocol. It accepts one word-level request at a time (write word, read word, assert or release the remote forced reset), serialises it into protocol bytes on a byte-wide UART transmit interface, collects the remote responder's reply bytes, and returns the result. It sits between a request source (loopback bench, second board, or boot loader) and an RS232 byte transceiver, and drives the far-end command processor over the link.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 32'd8333333: clkIn cycles allowed between successive reply bytes before the request aborts.
- ACK_BYTE, default 8'hAA: reply byte for write and reset commands.

Ports:
- clkIn  in  1  clock.
- rstIn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  high in IDLE only; request accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  request type: 0 write word, 1 read word, 2 assert force reset, 3 release force reset.
- cmd_addr  in  32  word address, for ops 0 and 1.
- cmd_data  in  32  write data, for op 0.
- rsp_valid  out  1  one-cycle pulse when a request completes.
- rsp_data  out  32  read word, valid with rsp_valid.
- rsp_error  out  1  set with rsp_valid on a bad ack or timeout.
- TX  out  8  byte to transmit.
- start_TX  out  1  one-cycle transmit strobe.
- TX_ready  in  1  transceiver idle.
- RX  in  8  received byte, valid while hasRX is high.
- hasRX  in  1  one-cycle pulse per received byte.
- busy  out  1  ~cmd_ready.

## Operation
- Opcode bytes: write 8'h01, read 8'h02, assert reset 8'h03, release reset 8'h04.
- Frame sent: opcode, then address as 4 bytes MSB first (ops 0 and 1), then data as 4 bytes MSB first (op 0 only).
- Transmit byte counts: 9 for write, 5 for read, 1 for either reset op.
- Expected reply:
  - Write and reset ops: 1 byte equal to ACK_BYTE.
  - Read: 4 bytes, assembled MSB first.
- On acceptance, cmd_op, cmd_addr and cmd_data are latched. Later input changes have no effect.
- States:
  - IDLE: go to LOAD on accept.
  - LOAD: place the next frame byte on TX. Assert start_TX if TX_ready=1, otherwise hold.
  - WAIT_LO: wait for TX_ready=0.
  - WAIT_HI: wait for TX_ready=1. Then go to LOAD if bytes remain, else go to RECV with the timeout counter cleared.
  - RECV: each hasRX pulse stores RX and clears the timeout counter. When the last expected byte arrives, go to DONE.
  - DONE: pulse rsp_valid for one cycle, then go to IDLE.
- hasRX pulses outside RECV are discarded.
- Any reply byte other than ACK_BYTE (write and reset ops) gives rsp_error=1 and rsp_data=0. The reply is still consumed fully.
- Timeout: the counter reaches TIMEOUT_CYCLES in RECV. Go to DONE with rsp_error=1, rsp_data = bytes collected so far, left-aligned and zero-filled.
- Read responses never flag a value error; any 4 bytes are accepted.
- rsp_data and rsp_error hold until the next rsp_valid.

## Timing
- Reset values: cmd_ready=1, busy=0, start_TX=0, TX=8'h00, rsp_valid=0, rsp_data=0, rsp_error=0, state IDLE.
- start_TX rules:
  - Registered; high for exactly one cycle.
  - Earliest assertion is the cycle after acceptance.
  - Never asserted while TX_ready=0.
  - TX is stable from the start_TX cycle until TX_ready returns high.
- Back-to-back bytes: the gap between strobes is at least 2 cycles, plus the transceiver's busy time.
- Response timing:
  - rsp_valid rises the cycle after the final hasRX sample, or the cycle after the timeout is detected.
  - cmd_ready rises the cycle after rsp_valid.
- A hasRX pulse and a timeout in the same cycle: the byte wins and the counter clears.
- rstIn low at any time, mid-frame included: immediate return to reset values. No further start_TX; the partial frame is abandoned.
- Timeout counter is 32 bits. It saturates and does not wrap.

## Test plan
- Write: op 0, addr 32'h0000_0010, data 32'hDEADBEEF, with a transceiver model that drops TX_ready 1 cycle after the strobe for 40 cycles, then reply 8'hAA. Required: TX sequence 01 00 00 00 10 DE AD BE EF, then rsp_valid with rsp_error=0.
- Read: op 1, addr 32'h0000_0004, reply bytes 12 34 56 78. Required: TX sequence 02 00 00 00 04, then rsp_data=32'h12345678 with rsp_error=0.
- Reset ops: op 2 with reply AA, then op 3 with reply 55. Required: TX bytes 03 then 04; first response rsp_error=0, second rsp_error=1.
- Timeout: TIMEOUT_CYCLES=100, read op, reply only 2 bytes AB CD. Required: rsp_valid exactly 100 cycles after the last byte, rsp_error=1, rsp_data=32'hABCD0000.
- Flow control and stray bytes: TX_ready held low 500 cycles at start, and a stray hasRX pulse injected during the send phase. Required: no strobe while TX_ready is low, and the stray byte does not count toward the reply.
- Reset mid-frame: drop rstIn after the 3rd strobe of a write. Required: all outputs at reset values, no further start_TX, and the next request completes normally.

Source files
------------

// File: rtl/serial_command_initiator.sv
// Host-side master for the serial memory-command link: serialises one word request
// into protocol bytes over a byte UART, then collects and checks the responder's reply.
module serial_command_initiator #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd8333333,
  parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [7:0]  TX,
  output logic        start_TX,
  input  logic        TX_ready,
  input  logic [7:0]  RX,
  input  logic        hasRX,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_LO, S_WAIT_HI, S_RECV, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] rx_buf_q, rx_buf_d;
  logic [31:0] tmo_q, tmo_d;
  logic        bad_q, bad_d;
  logic [7:0]  tx_q, tx_d;
  logic        start_tx_q, start_tx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [3:0]  tx_len;
  logic [2:0]  rx_len;
  logic [7:0]  frame_byte;
  logic [32:0] tmo_sum;
  logic        tmo_hit;

  always_comb begin
    tx_len = 4'd1;
    rx_len = 3'd1;
    case (op_q)
      2'd0:    tx_len = 4'd9;
      2'd1:    begin tx_len = 4'd5; rx_len = 3'd4; end
      default: ;
    endcase
    case (idx_q)
      4'd0:    frame_byte = {6'd0, op_q} + 8'd1;
      4'd1:    frame_byte = addr_q[31:24];
      4'd2:    frame_byte = addr_q[23:16];
      4'd3:    frame_byte = addr_q[15:8];
      4'd4:    frame_byte = addr_q[7:0];
      4'd5:    frame_byte = data_q[31:24];
      4'd6:    frame_byte = data_q[23:16];
      4'd7:    frame_byte = data_q[15:8];
      4'd8:    frame_byte = data_q[7:0];
      default: frame_byte = 8'h00;
    endcase
    // Fires so that rsp_valid lands exactly TIMEOUT_CYCLES cycles after the last byte:
    // counted cycles, plus this cycle, plus the DONE cycle.
    tmo_sum = {1'b0, tmo_q} + 33'd2;
    tmo_hit = (tmo_sum >= {1'b0, TIMEOUT_CYCLES});
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_valid) state_d = S_LOAD;
      S_LOAD:    if (TX_ready) state_d = S_WAIT_LO;
      S_WAIT_LO: if (!TX_ready) state_d = S_WAIT_HI;
      S_WAIT_HI: if (TX_ready) state_d = (idx_q == tx_len - 4'd1) ? S_RECV : S_LOAD;
      S_RECV: begin
        if (hasRX) begin
          if (rx_cnt_q == rx_len - 3'd1) state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    rx_cnt_d    = rx_cnt_q;
    rx_buf_d    = rx_buf_q;
    tmo_d       = tmo_q;
    bad_d       = bad_q;
    tx_d        = tx_q;
    start_tx_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          idx_d  = 4'd0;
        end
      end
      S_LOAD: begin
        if (TX_ready) begin
          tx_d       = frame_byte;
          start_tx_d = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (TX_ready) begin
          idx_d    = idx_q + 4'd1;
          rx_cnt_d = 3'd0;
          rx_buf_d = 32'd0;
          bad_d    = 1'b0;
          tmo_d    = 32'd0;
        end
      end
      S_RECV: begin
        if (hasRX) begin
          tmo_d    = 32'd0;
          rx_cnt_d = rx_cnt_q + 3'd1;
          // Only reads keep reply bytes; ack replies leave the buffer at zero.
          if (op_q == 2'd1) begin
            case (rx_cnt_q[1:0])
              2'd0: rx_buf_d[31:24] = RX;
              2'd1: rx_buf_d[23:16] = RX;
              2'd2: rx_buf_d[15:8]  = RX;
              2'd3: rx_buf_d[7:0]   = RX;
              default: ;
            endcase
          end else if (RX != ACK_BYTE) begin
            bad_d = 1'b1;
          end
          if (rx_cnt_q == rx_len - 3'd1) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = bad_d;
            rsp_data_d  = rx_buf_d;
          end
        end else begin
          tmo_d = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;
          if (tmo_hit) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_data_d  = rx_buf_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      op_q        <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      idx_q       <= 4'd0;
      rx_cnt_q    <= 3'd0;
      rx_buf_q    <= 32'd0;
      tmo_q       <= 32'd0;
      bad_q       <= 1'b0;
      tx_q        <= 8'h00;
      start_tx_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_buf_q    <= rx_buf_d;
      tmo_q       <= tmo_d;
      bad_q       <= bad_d;
      tx_q        <= tx_d;
      start_tx_q  <= start_tx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign TX        = tx_q;
  assign start_TX  = start_tx_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_serial_command_initiator.sv
// Directed bench for serial_command_initiator: transceiver model, reply driver,
// frame scoreboard and response/timing checks.
module tb_serial_command_initiator;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [7:0]  TX;
  logic        start_TX;
  logic        TX_ready;
  logic [7:0]  RX;
  logic        hasRX;
  logic        busy;

  logic        xcvr_ready;
  logic        hold_low;
  logic        drop_pend;
  int          busy_left;
  int          bad_strobe;
  logic [7:0]  tx_seen[$];
  logic [7:0]  exp_q[$];
  int          cyc = 0;
  int          t_last;
  int          n_cmp = 0;
  int          n_fail = 0;

  serial_command_initiator #(.TIMEOUT_CYCLES(32'd100), .ACK_BYTE(8'hAA)) dut (
    .clkIn(clkIn), .rstIn(rstIn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .TX(TX), .start_TX(start_TX), .TX_ready(TX_ready),
    .RX(RX), .hasRX(hasRX), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc <= cyc + 1;

  assign TX_ready = xcvr_ready & ~hold_low;

  // Transceiver model: capture byte on strobe, drop ready one cycle later for 40 cycles.
  always @(negedge clkIn) begin
    if (start_TX) begin
      tx_seen.push_back(TX);
      if (!TX_ready) bad_strobe++;
      drop_pend = 1'b1;
    end else if (drop_pend) begin
      drop_pend  = 1'b0;
      xcvr_ready = 1'b0;
      busy_left  = 40;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) xcvr_ready = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_start_TX"},  {31'd0, start_TX},  32'd0);
    check({tag, "_TX"},        {24'd0, TX},        32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_data"},  rsp_data,           32'd0);
    check({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
  endtask

  // Driver tasks
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clkIn);
    check("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clkIn);
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clkIn);
    RX     = b;
    hasRX  = 1'b1;
    t_last = cyc;
    @(negedge clkIn);
    hasRX  = 1'b0;
    RX     = $urandom_range(0, 255);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (tx_seen.size() < n && k < 5000) begin @(negedge clkIn); k++; end
    check("tx_byte_count", tx_seen.size(), n);
    k = 0;
    while ((!xcvr_ready || drop_pend || busy_left != 0) && k < 200) begin @(negedge clkIn); k++; end
    repeat (2) @(negedge clkIn);
  endtask

  task automatic check_frame();
    logic [7:0] b;
    logic [7:0] obs;
    while (exp_q.size() != 0) begin
      b   = exp_q.pop_front();
      obs = (tx_seen.size() != 0) ? tx_seen.pop_front() : 8'hxx;
      check("tx_byte", {24'd0, obs}, {24'd0, b});
    end
    tx_seen.delete();
  endtask

  task automatic wait_rsp(input int lat, input logic err, input logic [31:0] data, input bit chk_data);
    int k;
    k = 0;
    while (!rsp_valid && k < 400) begin @(negedge clkIn); k++; end
    check("rsp_seen",    {31'd0, rsp_valid}, 32'd1);
    check("rsp_latency", cyc - t_last, lat);
    check("rsp_error",   {31'd0, rsp_error}, {31'd0, err});
    if (chk_data) check("rsp_data", rsp_data, data);
    check("ready_during_rsp", {31'd0, cmd_ready}, 32'd0);
    @(negedge clkIn);
    check("rsp_one_cycle",   {31'd0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    check("busy_after_rsp",  {31'd0, busy},      32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstIn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 32'd0; cmd_data = 32'd0;
    RX = 8'h00; hasRX = 1'b0; hold_low = 1'b0; xcvr_ready = 1'b1;
    drop_pend = 1'b0; busy_left = 0; bad_strobe = 0; t_last = 0;
    repeat (3) @(negedge clkIn);
    check_reset_values("reset");
    rstIn = 1'b1;
    @(negedge clkIn);

    // Write word
    issue(2'd0, 32'h0000_0010, 32'hDEAD_BEEF);
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wait_tx(9);
    check_frame();
    send_rx(8'hAA);
    wait_rsp(1, 1'b0, 32'd0, 1'b0);

    // Read word
    issue(2'd1, 32'h0000_0004, 32'h5A5A_5A5A);
    exp_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h04};
    wait_tx(5);
    check_frame();
    send_rx(8'h12); @(negedge clkIn);
    send_rx(8'h34);
    send_rx(8'h56); repeat (3) @(negedge clkIn);
    send_rx(8'h78);
    wait_rsp(1, 1'b0, 32'h1234_5678, 1'b1);

    // Force-reset assert (good ack) then release (bad ack)
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q = '{8'h03};
    wait_tx(1);
    check_frame();
    send_rx(8'hAA);
    wait_rsp(1, 1'b0, 32'd0, 1'b1);
    issue(2'd3, 32'h1234_0000, 32'h0);
    exp_q = '{8'h04};
    wait_tx(1);
    check_frame();
    send_rx(8'h55);
    wait_rsp(1, 1'b1, 32'd0, 1'b1);
    repeat (10) @(negedge clkIn);
    check("rsp_error_hold", {31'd0, rsp_error}, 32'd1);

    // Timeout after two of four read bytes
    issue(2'd1, 32'h0000_0020, 32'h0);
    exp_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h20};
    wait_tx(5);
    check_frame();
    send_rx(8'hAB);
    send_rx(8'hCD);
    wait_rsp(100, 1'b1, 32'hABCD_0000, 1'b1);

    // Flow control and a stray byte during the send phase
    hold_low = 1'b1;
    issue(2'd1, 32'h0000_0008, 32'h0);
    repeat (500) @(negedge clkIn);
    check("no_strobe_while_low", tx_seen.size(), 0);
    hold_low = 1'b0;
    k = 0;
    while (tx_seen.size() < 2 && k < 500) begin @(negedge clkIn); k++; end
    send_rx(8'h99);
    exp_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h08};
    wait_tx(5);
    check_frame();
    check("strobe_while_not_ready", bad_strobe, 0);
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    send_rx(8'h44);
    wait_rsp(1, 1'b0, 32'h1122_3344, 1'b1);

    // Reset after the third strobe of a write
    issue(2'd0, 32'h0000_0030, 32'h0102_0304);
    k = 0;
    while (tx_seen.size() < 3 && k < 500) begin @(negedge clkIn); k++; end
    @(negedge clkIn);
    rstIn = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    repeat (5) @(negedge clkIn);
    rstIn = 1'b1;
    repeat (100) @(negedge clkIn);
    check("no_strobe_after_reset", tx_seen.size(), 3);
    tx_seen.delete();
    issue(2'd2, 32'h0, 32'h0);
    exp_q = '{8'h03};
    wait_tx(1);
    check_frame();
    send_rx(8'hAA);
    wait_rsp(1, 1'b0, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
